seq_mult8x8_core: RTL and testbench

SEQ_MULT8X8_CORE -- requirements
Module: seq_mult8x8_core

---
 rtl/seq_mult8x8_core.sv | 147 ++++++++++++++
 tb/tb_seq_mult8x8_core.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult8x8_core.sv
// Sequential 8x8 unsigned multiplier: four 4x4 partial products accumulated over four
// CALC cycles, followed by a one-cycle done pulse. All outputs come from registers/state.
module seq_mult8x8_core (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  dataa,
  input  logic [7:0]  datab,
  output logic [15:0] product,
  output logic        done,
  output logic        busy,
  output logic [2:0]  seg_code
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] product_q, product_d;

  logic [3:0]  nib_a, nib_b;
  logic [7:0]  pp;
  logic [15:0] term;
  logic [15:0] sum;

  // Nibble selection per step: lo*lo, hi*lo, lo*hi, hi*hi.
  always_comb begin
    nib_a = a_q[3:0];
    nib_b = b_q[3:0];
    unique case (step_q)
      2'd0: begin
        nib_a = a_q[3:0];
        nib_b = b_q[3:0];
      end
      2'd1: begin
        nib_a = a_q[7:4];
        nib_b = b_q[3:0];
      end
      2'd2: begin
        nib_a = a_q[3:0];
        nib_b = b_q[7:4];
      end
      2'd3: begin
        nib_a = a_q[7:4];
        nib_b = b_q[7:4];
      end
      default: ;
    endcase
  end

  assign pp = {4'h0, nib_a} * {4'h0, nib_b};

  always_comb begin
    term = {8'h00, pp};
    unique case (step_q)
      2'd0:    term = {8'h00, pp};
      2'd1,
      2'd2:    term = {4'h0, pp, 4'h0};
      2'd3:    term = {pp, 8'h00};
      default: term = {8'h00, pp};
    endcase
  end

  // Peak sum is 0xFE01, so the 16-bit add never wraps.
  assign sum = acc_q + term;

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    product_d = product_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = dataa;
          b_d     = datab;
          acc_d   = 16'h0000;
          step_d  = 2'd0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        acc_d  = sum;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          product_d = sum;
          state_d   = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      step_q    <= 2'd0;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      acc_q     <= 16'h0000;
      product_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  // Outputs decode state only, so no input-to-output combinational path exists.
  always_comb begin
    done     = 1'b0;
    busy     = 1'b0;
    seg_code = 3'b100;
    unique case (state_q)
      StIdle: seg_code = 3'b100;
      StCalc: begin
        busy     = 1'b1;
        seg_code = {1'b0, step_q};
      end
      StDone: begin
        done     = 1'b1;
        seg_code = 3'b111;
      end
      default: seg_code = 3'b100;
    endcase
  end

  assign product = product_q;

endmodule

// File: tb/tb_seq_mult8x8_core.sv
// Bench for seq_mult8x8_core: transaction-queue reference model checked every cycle,
// plus directed literal vectors and a randomized operand sweep.
module tb_seq_mult8x8_core;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  dataa;
  logic [7:0]  datab;
  logic [15:0] product;
  logic        done;
  logic        busy;
  logic [2:0]  seg_code;

  int checks;
  int failures;

  seq_mult8x8_core dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .dataa    (dataa),
    .datab    (datab),
    .product  (product),
    .done     (done),
    .busy     (busy),
    .seg_code (seg_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an accepted request expands into the cycle-by-cycle view it must
  // produce (four busy steps, then one done cycle carrying a*b). Empty queue means idle.
  typedef struct {
    logic [2:0]  seg;
    logic        bsy;
    logic        dn;
    logic [15:0] prod;
  } exp_t;

  exp_t        q[$];
  logic [15:0] model_prod;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      model_prod <= 16'h0000;
    end else if (q.size() != 0) begin
      model_prod <= q[0].prod;
      void'(q.pop_front());
    end else if (start) begin
      for (int s = 0; s < 4; s++) begin
        q.push_back('{seg: 3'(s), bsy: 1'b1, dn: 1'b0, prod: model_prod});
      end
      q.push_back('{seg: 3'b111, bsy: 1'b0, dn: 1'b1,
                    prod: {8'h00, dataa} * {8'h00, datab}});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) e = q[0];
    else e = '{seg: 3'b100, bsy: 1'b0, dn: 1'b0, prod: model_prod};
    checks++;
    if (seg_code !== e.seg || busy !== e.bsy || done !== e.dn || product !== e.prod) begin
      failures++;
      $display("FAIL cycle_model t=%0t: got seg=%0d busy=%b done=%b product=%h, required seg=%0d busy=%b done=%b product=%h",
               $time, seg_code, busy, done, product, e.seg, e.bsy, e.dn, e.prod);
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_product"}, product, 16'h0000);
    chk({name, "_done"}, {15'h0, done}, 16'h0000);
    chk({name, "_busy"}, {15'h0, busy}, 16'h0000);
    chk({name, "_seg"}, {13'h0, seg_code}, 16'h0004);
  endtask

  // Issue a one-cycle start and return the product seen in the done cycle.
  task automatic run_mult(input logic [7:0] a, input logic [7:0] b, output logic [15:0] res);
    bit seen;
    seen = 1'b0;
    res  = 16'hxxxx;
    @(negedge clk);
    dataa = a;
    datab = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (done) begin
        seen = 1'b1;
        res  = product;
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done pulse required done within 12 cycles");
    end
  endtask

  logic [15:0] res;
  logic [7:0]  ra, rb;
  int          gap;
  bit          gap_seen;

  initial begin
    checks   = 0;
    failures = 0;
    start    = 1'b0;
    dataa    = 8'h00;
    datab    = 8'h00;
    reset_n  = 1'b1;
    #1 reset_n = 1'b0;
    #1 chk_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Corner value with explicit step-code sequence.
    @(negedge clk);
    dataa = 8'hFF;
    datab = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ff_seg0", {13'h0, seg_code}, 16'h0000);
    @(negedge clk);
    chk("ff_seg1", {13'h0, seg_code}, 16'h0001);
    @(negedge clk);
    chk("ff_seg2", {13'h0, seg_code}, 16'h0002);
    @(negedge clk);
    chk("ff_seg3", {13'h0, seg_code}, 16'h0003);
    @(negedge clk);
    chk("ff_done", {15'h0, done}, 16'h0001);
    chk("ff_seg7", {13'h0, seg_code}, 16'h0007);
    chk("ff_product", product, 16'hFE01);

    run_mult(8'h00, 8'hA5, res);
    chk("zero_a5", res, 16'h0000);
    run_mult(8'h12, 8'h34, res);
    chk("x12_x34", res, 16'h03A8);

    // Previous result must hold through the next multiply's early steps.
    @(negedge clk);
    dataa = 8'h0F;
    datab = 8'hF0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("hold_step2_seg", {13'h0, seg_code}, 16'h0002);
    chk("hold_step2_product", product, 16'h03A8);
    @(negedge clk);
    @(negedge clk);
    chk("x0f_xf0", product, 16'h0E10);

    // Start held high; operands changed mid-CALC must not disturb the latched pair.
    @(negedge clk);
    dataa = 8'h21;
    datab = 8'h03;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    dataa = 8'h55;
    datab = 8'h02;
    gap      = 1;
    gap_seen = 1'b0;
    for (int i = 0; i < 12 && !gap_seen; i++) begin
      @(negedge clk);
      gap++;
      if (done) chk("reject_first", product, 16'h0063);
      if (gap > 4 && busy) gap_seen = 1'b1;
    end
    chk("reject_accept_gap", 16'(gap), 16'd6);
    start = 1'b0;
    for (int i = 0; i < 8 && !done; i++) @(negedge clk);
    chk("reject_second", product, 16'h00AA);

    // Asynchronous reset during step 2 aborts with no done pulse.
    @(negedge clk);
    dataa = 8'hAB;
    datab = 8'hCD;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_at_step2", {13'h0, seg_code}, 16'h0002);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("abort");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    run_mult(8'h07, 8'h09, res);
    chk("after_reset", res, 16'h003F);

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_mult(ra, rb, res);
      chk("sweep", res, {8'h00, ra} * {8'h00, rb});
    end

    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
